// File: rtl/bfp16_pkg.sv
// Shared BFP16 definitions.
//   bfp16_t        : 16-bit brain-float value {sign, exp[7:0], frac[6:0]}
//   BFP16_POS_ZERO : +0.0 encoding, the starting partial sum of every vector
//   dot_state_t    : states of the sequential dot-product controller
package bfp16_pkg;

  typedef logic [15:0] bfp16_t;

  localparam bfp16_t BFP16_POS_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dot_state_t;

endpackage

// File: rtl/bfp16_dot_seq.sv
// Sequential BFP16 dot-product controller. Feeds one (weight, ifmap) pair at a
// time to an external bfp16_mac together with the running partial sum, waits
// MAC_LAT cycles, captures the MAC result as the new partial sum, and after the
// pair flagged last presents the dot product on a valid/ready output.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   in_valid/in_ready         operand pair handshake
//   in_w, in_i, in_last       weight, ifmap, last-pair marker
//   mac_w, mac_i, mac_p       operands and partial sum to the MAC
//   mac_o                     MAC result
//   out_valid/out_ready       result handshake
//   out_data, out_count       dot product and number of pairs (saturating)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state, never on in_valid; out_valid is
// held with stable out_data/out_count until out_ready is seen. A source must
// hold its data while valid is high and ready is low.
module bfp16_dot_seq
  import bfp16_pkg::*;
#(
  parameter int MAC_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_w,
  input  logic [15:0]      in_i,
  input  logic             in_last,
  output logic [15:0]      mac_w,
  output logic [15:0]      mac_i,
  output logic [15:0]      mac_p,
  input  logic [15:0]      mac_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam int LAT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  // Current state is visible to checkers as u_dut.state.
  dot_state_t       state, state_n;
  bfp16_t           op_w, op_w_n;
  bfp16_t           op_i, op_i_n;
  logic             op_last, op_last_n;
  bfp16_t           acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [LAT_W-1:0] wait_cnt, wait_cnt_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      op_w     <= BFP16_POS_ZERO;
      op_i     <= BFP16_POS_ZERO;
      op_last  <= 1'b0;
      acc      <= BFP16_POS_ZERO;
      cnt      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      op_w     <= op_w_n;
      op_i     <= op_i_n;
      op_last  <= op_last_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    op_w_n     = op_w;
    op_i_n     = op_i;
    op_last_n  = op_last;
    acc_n      = acc;
    cnt_n      = cnt;
    wait_cnt_n = wait_cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_w_n     = in_w;
          op_i_n     = in_i;
          op_last_n  = in_last;
          wait_cnt_n = LAT_W'(MAC_LAT);
          state_n    = WAIT;
        end
      end
      WAIT: begin
        // Operands and partial sum stay put on mac_* for the whole wait; the
        // result is taken once the counter has drained to zero.
        if (wait_cnt != '0) begin
          wait_cnt_n = wait_cnt - LAT_W'(1);
        end else begin
          acc_n   = mac_o;
          cnt_n   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
          state_n = op_last ? DONE : IDLE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_n   = BFP16_POS_ZERO;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mac_w     = op_w;
  assign mac_i     = op_i;
  assign mac_p     = acc;
  assign out_data  = acc;
  assign out_count = cnt;

endmodule

// File: tb/tb_bfp16_dot_seq.sv
// Bench for bfp16_dot_seq. Three controller lanes with MAC_LAT = 1, 0, 3 each
// drive a behavioural BFP16 MAC whose result is only valid once the operands
// have been stable for MAC_LAT edges (garbage 16'hBAD0 otherwise).
module tb_bfp16_dot_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_w      [3];
  logic [15:0] in_i      [3];
  logic        in_last   [3];
  logic [15:0] mac_w     [3];
  logic [15:0] mac_i     [3];
  logic [15:0] mac_p     [3];
  logic [15:0] mac_o     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_data  [3];
  logic [7:0]  out_count [3];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- BFP16 helpers for the MAC model ----------------
  function automatic real bf_to_r(logic [15:0] b);
    real v;
    int  e;
    if (b[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(b[6:0]) / 128.0;
    e = int'(b[14:7]) - 127;
    for (int k = 0; k < e; k++) v = v * 2.0;
    for (int k = 0; k > e; k--) v = v / 2.0;
    return b[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r_to_bf(real v);
    logic s;
    int   e;
    int   f;
    real  a;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    for (int k = 0; k < 300 && a >= 2.0; k++) begin a = a / 2.0; e++; end
    for (int k = 0; k < 300 && a < 1.0; k++) begin a = a * 2.0; e--; end
    f = $rtoi((a - 1.0) * 128.0);
    return {s, e[7:0], f[6:0]};
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // ---------------- lanes: DUT + delayed MAC model ----------------
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [15:0] prev_w, prev_i, prev_p;
    int          age_r = 0;
    int          age_c;

    bfp16_dot_seq #(.MAC_LAT(LAT), .CNT_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_w      (in_w[g]),
      .in_i      (in_i[g]),
      .in_last   (in_last[g]),
      .mac_w     (mac_w[g]),
      .mac_i     (mac_i[g]),
      .mac_p     (mac_p[g]),
      .mac_o     (mac_o[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_count (out_count[g])
    );

    // age_c = rising edges since the MAC inputs last changed.
    always_comb begin
      if (mac_w[g] !== prev_w || mac_i[g] !== prev_i || mac_p[g] !== prev_p)
        age_c = 0;
      else
        age_c = (age_r < 1000) ? age_r + 1 : age_r;
      if (age_c >= LAT)
        mac_o[g] = r_to_bf(bf_to_r(mac_w[g]) * bf_to_r(mac_i[g]) + bf_to_r(mac_p[g]));
      else
        mac_o[g] = 16'hBAD0;
    end

    always @(posedge clk) begin
      prev_w <= mac_w[g];
      prev_i <= mac_i[g];
      prev_p <= mac_p[g];
      age_r  <= age_c;
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  // ---------------- drivers (called just after a falling edge) ----------------
  task automatic send_pair(input int k, input logic [15:0] w, input logic [15:0] i,
                           input logic last, output int hs);
    bit ok;
    ok          = 1'b0;
    in_w[k]     = w;
    in_i[k]     = i;
    in_last[k]  = last;
    in_valid[k] = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (in_ready[k] === 1'b1) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[k] = 1'b0;
    hs = cyc;
    chk($sformatf("lane%0d_in_handshake", k), 32'(ok), 32'd1);
  endtask

  task automatic wait_out(input int k, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (out_valid[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic get_result(input int k, input logic [15:0] ed, input logic [7:0] ec,
                            input string tag);
    bit ok;
    wait_out(k, ok);
    chk({tag, "_out_valid"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, "_out_data"},  32'(out_data[k]),  32'(ed));
      chk({tag, "_out_count"}, 32'(out_count[k]), 32'(ec));
      out_ready[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[k] = 1'b0;
      chk({tag, "_valid_drop"}, 32'(out_valid[k]), 32'd0);
      chk({tag, "_acc_clear"},  32'(out_data[k]),  32'd0);
      chk({tag, "_cnt_clear"},  32'(out_count[k]), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready[k]),  32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h0, h1, h2, h3;
    bit ok;

    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_w[k]      = 16'h0;
      in_i[k]      = 16'h0;
      in_last[k]   = 1'b0;
      out_ready[k] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset values on every lane.
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_in_ready", k),  32'(in_ready[k]),  32'd1);
      chk($sformatf("rst%0d_out_valid", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst%0d_out_data", k),  32'(out_data[k]),  32'd0);
      chk($sformatf("rst%0d_out_count", k), 32'(out_count[k]), 32'd0);
      chk($sformatf("rst%0d_mac_w", k),     32'(mac_w[k]),     32'd0);
      chk($sformatf("rst%0d_mac_p", k),     32'(mac_p[k]),     32'd0);
    end

    // 1: reset during WAIT of the second pair of a 3-pair vector.
    send_pair(0, 16'h3F80, 16'h4000, 1'b0, h0);
    send_pair(0, 16'h4040, 16'h3F00, 1'b0, h1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("t1_in_ready",  32'(in_ready[0]),  32'd1);
    chk("t1_out_valid", 32'(out_valid[0]), 32'd0);
    chk("t1_mac_p",     32'(mac_p[0]),     32'd0);
    chk("t1_mac_w",     32'(mac_w[0]),     32'd0);
    send_pair(0, 16'h3F80, 16'h4000, 1'b1, h0);
    get_result(0, 16'h4000, 8'd1, "t1");

    // 2: 1*2 + 3*0.5 = 3.5, pairs back to back.
    send_pair(0, 16'h3F80, 16'h4000, 1'b0, h0);
    send_pair(0, 16'h4040, 16'h3F00, 1'b1, h1);
    chk("t2_spacing", 32'(h1 - h0), 32'd3);
    get_result(0, 16'h4060, 8'd2, "t2");

    // 3: single pair 2*3 = 6, P must be +0 while waiting.
    send_pair(0, 16'h4000, 16'h4040, 1'b1, h0);
    chk("t3_mac_p", 32'(mac_p[0]), 32'h0000);
    chk("t3_mac_w", 32'(mac_w[0]), 32'h4000);
    chk("t3_mac_i", 32'(mac_i[0]), 32'h4040);
    get_result(0, 16'h40C0, 8'd1, "t3");

    // 4: result held under back-pressure, input pulses ignored.
    send_pair(0, 16'h3F80, 16'h3F80, 1'b1, h0);
    wait_out(0, ok);
    chk("t4_out_valid", 32'(ok), 32'd1);
    for (int t = 0; t < 5; t++) begin
      in_w[0]     = 16'h1234;
      in_i[0]     = 16'h5678;
      in_valid[0] = t[0];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t4_hold_valid_%0d", t), 32'(out_valid[0]), 32'd1);
      chk($sformatf("t4_hold_data_%0d", t),  32'(out_data[0]),  32'h3F80);
      chk($sformatf("t4_hold_mac_w_%0d", t), 32'(mac_w[0]),     32'h3F80);
    end
    in_valid[0] = 1'b0;
    get_result(0, 16'h3F80, 8'd1, "t4");

    // 5: MAC_LAT = 0 and 3, four pairs of 1*1.
    for (int k = 1; k < 3; k++) begin
      send_pair(k, 16'h3F80, 16'h3F80, 1'b0, h0);
      send_pair(k, 16'h3F80, 16'h3F80, 1'b0, h1);
      send_pair(k, 16'h3F80, 16'h3F80, 1'b0, h2);
      send_pair(k, 16'h3F80, 16'h3F80, 1'b1, h3);
      chk($sformatf("t5_lane%0d_spacing_a", k), 32'(h1 - h0), 32'(lat_of(k) + 2));
      chk($sformatf("t5_lane%0d_spacing_b", k), 32'(h3 - h2), 32'(lat_of(k) + 2));
      get_result(k, 16'h4080, 8'd4, $sformatf("t5_lane%0d", k));
    end

    // 6: 300 zero pairs, count saturates at 255.
    for (int n = 0; n < 300; n++) begin
      n_chk = n_chk;
      send_pair(0, 16'h0000, 16'h0000, (n == 299), h0);
    end
    get_result(0, 16'h0000, 8'd255, "t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
